div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Sequences the shared 32-bit iterative divider for the EX stage.
- Accepts one tagged divide request at a time and launches it on the divider.
- Tracks completion through the divider's stall signal, captures {remainder, quotient} and returns it on a valid/ready response port.
- Handles pipeline flush, divide-by-zero flagging and a hang watchdog. The parent instantiates both this block and the divider.

Parameters:
- DW, 32, operand width; must match the divider.
- TAG_W, 5, request tag width (destination/ROB id).
- TIMEOUT, 40, BUSY cycles before the watchdog fires; must be > DW+1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; aborts any operation
- req_valid  in  1  divide request
- req_ready  out  1  request accepted when high together with req_valid
- req_sign  in  1  1 = signed divide
- req_a  in  DW  dividend
- req_b  in  DW  divisor
- req_tag  in  TAG_W  request tag
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes the result
- rsp_quot  out  DW  quotient
- rsp_rem  out  DW  remainder
- rsp_tag  out  TAG_W  tag of the request
- rsp_dz  out  1  divisor was zero
- ctrl_stall  out  1  pipeline stall request
- div_valid  out  1  start pulse to the divider
- div_sign  out  1  sign mode to the divider
- div_a  out  DW  dividend to the divider
- div_b  out  DW  divisor to the divider
- div_flush  out  1  abort to the divider
- div_stall  in  1  divider busy
- div_result  in  2*DW  divider output, {rem, quot}
- err_timeout  out  1  sticky watchdog error

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; rsp_valid, div_valid, div_flush, ctrl_stall and err_timeout all 0; rsp_quot, rsp_rem, rsp_tag, rsp_dz, div_a and div_b all 0.
- FSM states: IDLE, START, BUSY, DONE.
- IDLE:
  - req_ready = ~flush.
  - On handshake, register a, b, sign and tag, and set dz = (b==0).
  - Next state is START.
- START:
  - div_valid = 1 for exactly this cycle; div_a, div_b and div_sign are driven from registers.
  - Next state is BUSY. Clear the watchdog counter and the seen_busy flag.
- BUSY:
  - Set seen_busy when div_stall==1.
  - When seen_busy & ~div_stall: capture div_result into rsp_rem/rsp_quot and go to DONE.
  - Count cycles. If the count reaches TIMEOUT, set err_timeout (cleared only by rst), pulse div_flush for one cycle and go to IDLE with no response.
- DONE:
  - rsp_valid = 1. All rsp_* outputs are held stable until rsp_ready.
  - rsp_valid & rsp_ready moves the FSM to IDLE.
  - req_ready stays 0 in DONE; there is a one-cycle bubble before the next request.
- Latency: the handshake cycle is 0, START is 1, div_stall is high in cycles 2-33, capture happens in cycle 34, and rsp_valid first rises in cycle 35.
- ctrl_stall = START | BUSY | (DONE & ~rsp_ready).
- Flush:
  - In any state, flush forces IDLE on the next edge.
  - div_flush = flush | watchdog pulse.
  - A pending response is discarded.
  - flush wins over a simultaneous request; the request is not accepted.
- Reset mid-operation behaves like flush, but also clears err_timeout.
- Result data is passed through unmodified, with no re-signing; the divider already applies sign correction.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - A request with req_b==0 goes from IDLE directly to DONE and never starts the divider.
  - Response: rsp_quot = all ones, rsp_rem = req_a, rsp_dz = 1.
  - rsp_valid rises in cycle 1.
- Undefined:
  - A zero divisor takes the normal 35-cycle path.
  - The divider's raw result is returned, with rsp_dz = 1.

Decomposition:
- Package div_ctrl_pkg holds:
  - the state enum {IDLE, START, BUSY, DONE};
  - the DW, TAG_W and TIMEOUT defaults;
  - a response struct {tag, dz, rem, quot}.
- No sub-module. The watchdog counter and FSM are inline, and the divider stays external.

Test Plan:
- Unsigned 100/7, tag 3: rsp_valid in cycle 35 with quot=14, rem=2, tag=3, dz=0; div_valid is a single pulse in cycle 1; ctrl_stall is high in cycles 1-34.
- Signed -7/2 (0xFFFFFFF9 / 2): rsp_quot=0xFFFFFFFD, rsp_rem=0xFFFFFFFF.
- flush at BUSY cycle 10: div_flush pulses in that cycle, the FSM is IDLE next cycle, no rsp_valid appears, and a new request is accepted the following cycle.
- rsp_ready held low for 5 cycles in DONE: rsp_* are stable, ctrl_stall=1 and req_ready=0. The cycle after rsp_ready=1, the FSM is IDLE.
- a=0x1234, b=0:
  - with DIV_ZERO_FAST_EN: rsp_valid in cycle 1 with quot=0xFFFFFFFF, rem=0x1234, dz=1, and div_valid is never asserted;
  - without it: rsp_valid in cycle 35 with dz=1.
- Divider model holds div_stall high indefinitely: err_timeout rises at BUSY count 40, div_flush pulses, the FSM returns to IDLE, and err_timeout stays 1 until rst.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// div_ctrl_pkg: shared types and defaults for the divider issue controller.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package div_ctrl_pkg;

  localparam int DEF_DW      = 32;
  localparam int DEF_TAG_W   = 5;
  localparam int DEF_TIMEOUT = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DEF_TAG_W-1:0] tag;
    logic                 dz;
    logic [DEF_DW-1:0]    rem;
    logic [DEF_DW-1:0]    quot;
  } rsp_t;

endpackage

`default_nettype wire

// File: rtl/div_issue_ctrl_if.sv
// ----------------------------------------------------------------------------
// div_issue_ctrl_if: request, response and divider-side signals of the issue controller.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface div_issue_ctrl_if
  import div_ctrl_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int TAG_W = DEF_TAG_W
) ();

  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic             req_sign;
  logic [DW-1:0]    req_a;
  logic [DW-1:0]    req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DW-1:0]    rsp_quot;
  logic [DW-1:0]    rsp_rem;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_dz;
  logic             ctrl_stall;
  logic             div_valid;
  logic             div_sign;
  logic [DW-1:0]    div_a;
  logic [DW-1:0]    div_b;
  logic             div_flush;
  logic             div_stall;
  logic [2*DW-1:0]  div_result;
  logic             err_timeout;

  // Pipeline / divider side.
  modport master (
    output flush, req_valid, req_sign, req_a, req_b, req_tag, rsp_ready,
           div_stall, div_result,
    input  req_ready, rsp_valid, rsp_quot, rsp_rem, rsp_tag, rsp_dz,
           ctrl_stall, div_valid, div_sign, div_a, div_b, div_flush, err_timeout
  );

  // Issue controller side.
  modport slave (
    input  flush, req_valid, req_sign, req_a, req_b, req_tag, rsp_ready,
           div_stall, div_result,
    output req_ready, rsp_valid, rsp_quot, rsp_rem, rsp_tag, rsp_dz,
           ctrl_stall, div_valid, div_sign, div_a, div_b, div_flush, err_timeout
  );

endinterface

`default_nettype wire

// File: rtl/div_issue_ctrl.sv
// ----------------------------------------------------------------------------
// div_issue_ctrl: launches tagged divides on the shared divider and returns results.
// Option macro: DIV_ZERO_FAST_EN (zero divisor answered without the divider).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  div_issue_ctrl_if.slave bus
);

  localparam int               CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [DW-1:0]    r_a;
  logic [DW-1:0]    r_b;
  logic             r_sign;
  rsp_t             r_rsp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_seen_busy;
  logic             r_err;

  logic             w_req_ready;
  logic             w_req_fire;
  logic             w_div_valid;
  logic             w_capture;
  logic             w_wd_fire;

  assign w_req_fire = w_req_ready & bus.req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_div_valid = 1'b0;
    w_capture   = 1'b0;
    w_wd_fire   = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = ~bus.flush;
        if (bus.req_valid && !bus.flush) begin
`ifdef DIV_ZERO_FAST_EN
          w_next = (bus.req_b == '0) ? DONE : START;
`else
          w_next = START;
`endif
        end
      end
      START: begin
        w_div_valid = 1'b1;
        w_next      = BUSY;
      end
      BUSY: begin
        // Completion is the falling edge of div_stall after it was seen high.
        if (r_seen_busy && !bus.div_stall) begin
          w_capture = 1'b1;
          w_next    = DONE;
        end else if (r_cnt == C_CNT_LAST) begin
          w_wd_fire = 1'b1;
          w_next    = IDLE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    if (bus.flush) begin
      w_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sign      <= 1'b0;
      r_rsp       <= '0;
      r_cnt       <= '0;
      r_seen_busy <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_a       <= bus.req_a;
        r_b       <= bus.req_b;
        r_sign    <= bus.req_sign;
        r_rsp.tag <= DEF_TAG_W'(bus.req_tag);
        r_rsp.dz  <= (bus.req_b == '0);
`ifdef DIV_ZERO_FAST_EN
        if (bus.req_b == '0) begin
          r_rsp.quot <= '1;
          r_rsp.rem  <= DEF_DW'(bus.req_a);
        end
`endif
      end
      if (r_state == START) begin
        r_cnt       <= '0;
        r_seen_busy <= 1'b0;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        if (bus.div_stall) begin
          r_seen_busy <= 1'b1;
        end
      end
      // Divider already applies sign correction; result is stored raw.
      if (w_capture) begin
        {r_rsp.rem, r_rsp.quot} <= bus.div_result;
      end
      if (w_wd_fire) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.rsp_valid   = (r_state == DONE);
  assign bus.rsp_quot    = DW'(r_rsp.quot);
  assign bus.rsp_rem     = DW'(r_rsp.rem);
  assign bus.rsp_tag     = TAG_W'(r_rsp.tag);
  assign bus.rsp_dz      = r_rsp.dz;
  assign bus.ctrl_stall  = (r_state == START) || (r_state == BUSY) ||
                           ((r_state == DONE) && !bus.rsp_ready);
  assign bus.div_valid   = w_div_valid;
  assign bus.div_sign    = r_sign;
  assign bus.div_a       = r_a;
  assign bus.div_b       = r_b;
  assign bus.div_flush   = bus.flush | w_wd_fire;
  assign bus.err_timeout = r_err;

endmodule

`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_div_issue_ctrl: directed bench for div_issue_ctrl with a 32-cycle divider stand-in.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_div_issue_ctrl;
  import div_ctrl_pkg::*;

  localparam int DW    = 32;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_issue_ctrl_if #(.DW(DW), .TAG_W(TAG_W)) bus ();

  div_issue_ctrl #(.DW(DW), .TAG_W(TAG_W), .TIMEOUT(40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Divider stand-in: stall high for 32 cycles after the start pulse, or forever in hang mode.
  logic        m_hang;
  int          m_cnt;
  logic        m_forever;
  logic [63:0] m_res;
  int          m_starts;

  function automatic logic [63:0] model_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      m_cnt     <= 0;
      m_forever <= 1'b0;
      m_res     <= '0;
      m_starts  <= 0;
    end else begin
      if (bus.div_flush) begin
        m_cnt     <= 0;
        m_forever <= 1'b0;
      end else if (bus.div_valid) begin
        m_res <= model_div(bus.div_sign, bus.div_a, bus.div_b);
        if (m_hang) m_forever <= 1'b1;
        else        m_cnt     <= 32;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
      end
      if (bus.div_valid) m_starts <= m_starts + 1;
    end
  end

  assign bus.div_stall  = (m_cnt != 0) || m_forever;
  assign bus.div_result = m_res;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in the current cycle (cycle 0) and returns in cycle 1.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    bus.req_valid = 1'b1;
    bus.req_sign  = s;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = t;
    #1;
    chk("req_ready_at_issue", {63'd0, bus.req_ready}, 64'd1);
    tick();
    bus.req_valid = 1'b0;
    #1;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int s0;
    int n_dv;
    int n_stl_lo;
    int n_early;
    int n_bad;

    rst           = 1'b1;
    m_hang        = 1'b0;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_sign  = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_div_valid", {63'd0, bus.div_valid}, 64'd0);
    chk("rst_ctrl_stall", {63'd0, bus.ctrl_stall}, 64'd0);
    chk("rst_err", {63'd0, bus.err_timeout}, 64'd0);
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_rsp_quot", {32'd0, bus.rsp_quot}, 64'd0);
    chk("rst_div_a", {32'd0, bus.div_a}, 64'd0);

    // Unsigned 100/7 tag 3
    s0 = m_starts;
    issue(1'b0, 32'd100, 32'd7, 5'd3);
    chk("t1_div_valid_c1", {63'd0, bus.div_valid}, 64'd1);
    chk("t1_div_a", {32'd0, bus.div_a}, 64'd100);
    chk("t1_div_b", {32'd0, bus.div_b}, 64'd7);
    chk("t1_div_sign", {63'd0, bus.div_sign}, 64'd0);
    n_dv = 0; n_stl_lo = 0; n_early = 0;
    for (int c = 1; c <= 34; c++) begin
      if (bus.div_valid === 1'b1) n_dv++;
      if (bus.ctrl_stall !== 1'b1) n_stl_lo++;
      if (bus.rsp_valid !== 1'b0) n_early++;
      tick();
    end
    chk("t1_div_valid_pulses", 64'(n_dv), 64'd1);
    chk("t1_div_starts", 64'(m_starts - s0), 64'd1);
    chk("t1_stall_gaps", 64'(n_stl_lo), 64'd0);
    chk("t1_early_rsp", 64'(n_early), 64'd0);
    chk("t1_rsp_valid_c35", {63'd0, bus.rsp_valid}, 64'd1);
    chk("t1_quot", {32'd0, bus.rsp_quot}, 64'd14);
    chk("t1_rem", {32'd0, bus.rsp_rem}, 64'd2);
    chk("t1_tag", {59'd0, bus.rsp_tag}, 64'd3);
    chk("t1_dz", {63'd0, bus.rsp_dz}, 64'd0);
    chk("t1_stall_done_ready", {63'd0, bus.ctrl_stall}, 64'd0);
    tick();
    chk("t1_rsp_valid_after", {63'd0, bus.rsp_valid}, 64'd0);
    chk("t1_idle_after", {63'd0, bus.req_ready}, 64'd1);

    // Signed -7/2 tag 5
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 5'd5);
    wait_rsp(lat);
    chk("t2_latency", 64'(lat), 64'd35);
    chk("t2_quot", {32'd0, bus.rsp_quot}, 64'hFFFF_FFFD);
    chk("t2_rem", {32'd0, bus.rsp_rem}, 64'hFFFF_FFFF);
    chk("t2_tag", {59'd0, bus.rsp_tag}, 64'd5);
    tick();

    // Flush in BUSY cycle 10 (absolute cycle 11)
    issue(1'b0, 32'd50, 32'd5, 5'd7);
    repeat (10) tick();
    bus.flush = 1'b1;
    #1;
    chk("t3_div_flush", {63'd0, bus.div_flush}, 64'd1);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("t3_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    chk("t3_idle_stall", {63'd0, bus.ctrl_stall}, 64'd0);
    issue(1'b0, 32'd50, 32'd5, 5'd7);
    wait_rsp(lat);
    chk("t3_latency", 64'(lat), 64'd35);
    chk("t3_quot", {32'd0, bus.rsp_quot}, 64'd10);
    chk("t3_rem", {32'd0, bus.rsp_rem}, 64'd0);
    tick();

    // Flush beats a simultaneous request
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_a     = 32'd9;
    bus.req_b     = 32'd3;
    #1;
    chk("t3b_req_ready_flush", {63'd0, bus.req_ready}, 64'd0);
    tick();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("t3b_not_started_stall", {63'd0, bus.ctrl_stall}, 64'd0);
    chk("t3b_not_started_dv", {63'd0, bus.div_valid}, 64'd0);

    // Back-pressure in DONE for 5 cycles
    bus.rsp_ready = 1'b0;
    issue(1'b0, 32'd1000, 32'd3, 5'd9);
    wait_rsp(lat);
    chk("t4_latency", 64'(lat), 64'd35);
    n_bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (!(bus.rsp_valid === 1'b1 && bus.rsp_quot === 32'd333 && bus.rsp_rem === 32'd1 &&
            bus.rsp_tag === 5'd9 && bus.ctrl_stall === 1'b1 && bus.req_ready === 1'b0))
        n_bad++;
      tick();
    end
    chk("t4_hold_stable", 64'(n_bad), 64'd0);
    bus.rsp_ready = 1'b1;
    #1;
    chk("t4_stall_released", {63'd0, bus.ctrl_stall}, 64'd0);
    tick();
    chk("t4_rsp_gone", {63'd0, bus.rsp_valid}, 64'd0);
    chk("t4_idle", {63'd0, bus.req_ready}, 64'd1);

    // Divide by zero
    s0 = m_starts;
    issue(1'b0, 32'h0000_1234, 32'd0, 5'd2);
`ifdef DIV_ZERO_FAST_EN
    chk("t5_fast_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    chk("t5_fast_quot", {32'd0, bus.rsp_quot}, 64'hFFFF_FFFF);
    chk("t5_fast_rem", {32'd0, bus.rsp_rem}, 64'h1234);
    chk("t5_fast_dz", {63'd0, bus.rsp_dz}, 64'd1);
    tick();
    chk("t5_fast_no_start", 64'(m_starts - s0), 64'd0);
`else
    wait_rsp(lat);
    chk("t5_latency", 64'(lat), 64'd35);
    chk("t5_dz", {63'd0, bus.rsp_dz}, 64'd1);
    chk("t5_quot", {32'd0, bus.rsp_quot}, 64'hFFFF_FFFF);
    chk("t5_rem", {32'd0, bus.rsp_rem}, 64'h1234);
    chk("t5_started", 64'(m_starts - s0), 64'd1);
    tick();
`endif

    // Watchdog: divider never finishes
    m_hang = 1'b1;
    issue(1'b0, 32'd8, 32'd2, 5'd1);
    repeat (39) tick();
    chk("t6_no_early_flush", {63'd0, bus.div_flush}, 64'd0);
    chk("t6_no_early_err", {63'd0, bus.err_timeout}, 64'd0);
    tick();
    chk("t6_wd_flush", {63'd0, bus.div_flush}, 64'd1);
    tick();
    chk("t6_err_set", {63'd0, bus.err_timeout}, 64'd1);
    chk("t6_idle", {63'd0, bus.req_ready}, 64'd1);
    chk("t6_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
    chk("t6_flush_pulse_end", {63'd0, bus.div_flush}, 64'd0);
    m_hang = 1'b0;
    issue(1'b0, 32'd9, 32'd4, 5'd4);
    wait_rsp(lat);
    chk("t6_next_quot", {32'd0, bus.rsp_quot}, 64'd2);
    chk("t6_next_rem", {32'd0, bus.rsp_rem}, 64'd1);
    chk("t6_err_sticky", {63'd0, bus.err_timeout}, 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_err_cleared", {63'd0, bus.err_timeout}, 64'd0);
    chk("t6_rst_quot", {32'd0, bus.rsp_quot}, 64'd0);
    chk("t6_rst_tag", {59'd0, bus.rsp_tag}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
